// File: rtl/pio_pkg.sv
// pio_pkg: shared types for the PIO host sequencer.
// Bus action codes, sequencer states, config-entry field offsets.
package pio_pkg;

  localparam logic [5:0] ACT_NOP   = 6'd0;
  localparam logic [5:0] ACT_INSTR = 6'd1;
  localparam logic [5:0] ACT_PUSH  = 6'd4;

  // conf_data = {mindex, action, data}
  localparam int CF_DATA_LSB = 0;
  localparam int CF_ACT_LSB  = 32;
  localparam int CF_MIDX_LSB = 36;

  typedef enum logic [1:0] {
    S_LOAD,
    S_CONF,
    S_RUN
  } state_t;

  function automatic logic [1:0] oh2idx(
    input logic [3:0] oh
  );
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      oh[0]:   r = 2'd0;
      oh[1]:   r = 2'd1;
      oh[2]:   r = 2'd2;
      oh[3]:   r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: 4-way round-robin arbiter, one-hot grant.
// req: requests; last: previous grant; gnt: search starts at last+1.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] gnt
);

  logic [1:0] idx;
  logic       hit;

  always_comb begin
    gnt = '0;
    hit = 1'b0;
    idx = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!hit && req[idx]) begin
        gnt[idx] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_host_sched.sv
// pio_host_sched: PIO command-bus sequencer (load, config, stream).
// ROM ports prog_*/conf_*, streams s_*, bus din/index/action/mindex.
module pio_host_sched
  import pio_pkg::*;
#(
  parameter int PROG_LEN = 32,
  parameter int CONF_LEN = 5,
  parameter int PACE     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         restart,
  output logic [4:0]   prog_addr,
  input  logic [15:0]  prog_data,
  output logic [4:0]   conf_addr,
  input  logic [37:0]  conf_data,
  input  logic [3:0]   s_valid,
  input  logic [127:0] s_data,
  output logic [3:0]   s_ready,
  input  logic [3:0]   tx_full,
  output logic [31:0]  din,
  output logic [4:0]   index,
  output logic [5:0]   action,
  output logic [1:0]   mindex,
  output logic         running
);

  localparam logic [5:0] P_LEN = 6'(PROG_LEN);
  localparam logic [5:0] C_LEN = 6'(CONF_LEN);
  // one idle cycle separates the sweeps; with no config
  // we wait for the last instruction to reach the bus
  localparam logic [5:0] LOAD_END =
    (CONF_LEN == 0) ? 6'(PROG_LEN + 1) : 6'(PROG_LEN);
  localparam logic [5:0] CONF_END = 6'(CONF_LEN + 1);
  localparam logic [7:0] PACE_LD  = 8'(PACE - 1);

  state_t      state;
  logic [5:0]  cnt;
  logic [5:0]  cnt_nx;
  logic        iss_v;
  logic        rd_v;
  logic        rd_conf;
  logic [4:0]  rd_addr;
  logic [7:0]  pace [4];
  logic [1:0]  last;
  logic [3:0]  elig;
  logic [1:0]  gidx;
  logic [31:0] gword;

  always_comb begin
    cnt_nx = cnt + 6'd1;
    iss_v  = ((state == S_LOAD) && (cnt < P_LEN))
          || ((state == S_CONF) && (cnt < C_LEN));
    for (int i = 0; i < 4; i++) begin
      elig[i] = s_valid[i] && !tx_full[i]
             && (pace[i] == 8'd0)
             && (state == S_RUN);
    end
  end

  rr_arb4 u_arb (
    .req  (elig),
    .last (last),
    .gnt  (s_ready)
  );

  assign gidx  = oh2idx(s_ready);
  assign gword = s_data[{gidx, 5'd0} +: 32];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LOAD;
      cnt       <= '0;
      prog_addr <= '0;
      conf_addr <= '0;
      rd_v      <= 1'b0;
      rd_conf   <= 1'b0;
      rd_addr   <= '0;
      din       <= '0;
      index     <= '0;
      action    <= ACT_NOP;
      mindex    <= '0;
      running   <= 1'b0;
      // search begins at channel 0 after reset
      last      <= 2'd3;
      for (int i = 0; i < 4; i++) pace[i] <= '0;
    end else begin
      // ROM read stage: address issued now, data next cycle
      rd_v    <= iss_v;
      rd_conf <= (state == S_CONF);
      rd_addr <= cnt[4:0];

      if (rd_v && !rd_conf) begin
        action <= ACT_INSTR;
        index  <= rd_addr;
        din    <= {16'h0, prog_data};
        mindex <= 2'd0;
      end else if (rd_v) begin
        action <= {2'b0, conf_data[CF_ACT_LSB +: 4]};
        index  <= 5'd0;
        din    <= conf_data[CF_DATA_LSB +: 32];
        mindex <= conf_data[CF_MIDX_LSB +: 2];
      end else if (|s_ready) begin
        action <= ACT_PUSH;
        index  <= 5'd0;
        din    <= gword;
        mindex <= gidx;
      end else begin
        action <= ACT_NOP;
      end

      for (int i = 0; i < 4; i++) begin
        if (s_ready[i]) pace[i] <= PACE_LD;
        else if (pace[i] != 8'd0) pace[i] <= pace[i] - 8'd1;
      end
      if (|s_ready) last <= gidx;

      unique case (state)
        S_LOAD: begin
          if (cnt == LOAD_END) begin
            cnt       <= '0;
            conf_addr <= '0;
            if (CONF_LEN == 0) begin
              state   <= S_RUN;
              running <= 1'b1;
            end else begin
              state <= S_CONF;
            end
          end else begin
            cnt <= cnt_nx;
            if (cnt_nx < P_LEN) prog_addr <= cnt_nx[4:0];
          end
        end
        S_CONF: begin
          if (cnt == CONF_END) begin
            cnt     <= '0;
            state   <= S_RUN;
            running <= 1'b1;
          end else begin
            cnt <= cnt_nx;
            if (cnt_nx < C_LEN) conf_addr <= cnt_nx[4:0];
          end
        end
        S_RUN: begin
          if (restart) begin
            state     <= S_LOAD;
            running   <= 1'b0;
            cnt       <= '0;
            prog_addr <= '0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_host_sched.sv
// tb_pio_host_sched: directed bench for pio_host_sched.
// A timeline/arbitration model is compared every cycle.
module tb_pio_host_sched;

  localparam int P    = 32;
  localparam int C    = 5;
  localparam int PACE = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         restart;
  logic [4:0]   prog_addr;
  logic [15:0]  prog_data;
  logic [4:0]   conf_addr;
  logic [37:0]  conf_data;
  logic [3:0]   s_valid;
  logic [127:0] s_data;
  logic [3:0]   s_ready;
  logic [3:0]   tx_full;
  logic [31:0]  din;
  logic [4:0]   index;
  logic [5:0]   action;
  logic [1:0]   mindex;
  logic         running;

  always #5 clk = ~clk;

  pio_host_sched #(
    .PROG_LEN (P),
    .CONF_LEN (C),
    .PACE     (PACE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .conf_addr (conf_addr),
    .conf_data (conf_data),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .tx_full   (tx_full),
    .din       (din),
    .index     (index),
    .action    (action),
    .mindex    (mindex),
    .running   (running)
  );

  logic [15:0] prog_rom [32];
  logic [37:0] conf_rom [32];

  always @(posedge clk) begin
    prog_data <= prog_rom[prog_addr];
    conf_data <= conf_rom[conf_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [3:0] rlog [256];
  logic [3:0] seq_a [12] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd0,
                             4'd0, 4'd0, 4'd1, 4'd2, 4'd4, 4'd8};

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               nm, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mdl_on = 0;
  bit          rst_m  = 0;
  bit          run_m  = 0;
  int          L      = 0;
  int          tabs   = 0;
  int          lastch = 3;
  int          g;
  int          last_t [4];
  logic [5:0]  e_act;
  logic [31:0] e_din;
  logic [1:0]  e_mi;
  logic [4:0]  e_idx;
  bit          idx_on = 0;
  logic [3:0]  e_rdy;
  logic [37:0] ent;

  always @(negedge clk) begin
    g = -1;
    if (run_m) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (lastch + k) % 4;
        if (g < 0 && s_valid[c] && !tx_full[c]
            && (tabs - last_t[c] >= PACE))
          g = c;
      end
    end
    e_rdy = (g < 0) ? 4'd0 : 4'(1 << g);
    rlog[cyc % 256] = s_ready;

    if (mdl_on) begin
      chk("action", {26'd0, action}, {26'd0, e_act});
      chk("din", din, e_din);
      chk("mindex", {30'd0, mindex}, {30'd0, e_mi});
      chk("running", {31'd0, running}, {31'd0, run_m});
      chk("s_ready", {28'd0, s_ready}, {28'd0, e_rdy});
      if (idx_on)
        chk("index", {27'd0, index}, {27'd0, e_idx});
      if (!run_m && L < P)
        chk("prog_addr", {27'd0, prog_addr}, L);
      if (rst_m)
        chk("conf_addr", {27'd0, conf_addr}, 0);
      else if (!run_m && L >= P + 1 && L <= P + C)
        chk("conf_addr", {27'd0, conf_addr}, L - P - 1);
    end

    if (reset) begin
      mdl_on = 1;
      rst_m  = 1;
      run_m  = 0;
      L      = 0;
      lastch = 3;
      for (int i = 0; i < 4; i++) last_t[i] = -1000;
      e_act  = 6'd0;
      e_din  = 32'd0;
      e_mi   = 2'd0;
      e_idx  = 5'd0;
      idx_on = 1;
    end else begin
      rst_m  = 0;
      idx_on = 0;
      if (run_m) begin
        if (g >= 0) begin
          e_act     = 6'd4;
          e_mi      = 2'(g);
          e_din     = s_data[32*g +: 32];
          last_t[g] = tabs;
          lastch    = g;
        end else begin
          e_act = 6'd0;
        end
        if (restart) begin
          run_m = 0;
          L     = 0;
        end
      end else begin
        L++;
        if (L >= 2 && L <= P + 1) begin
          e_act  = 6'd1;
          e_idx  = 5'(L - 2);
          e_din  = {16'h0, prog_rom[L-2]};
          e_mi   = 2'd0;
          idx_on = 1;
        end else if (L >= P + 3 && L <= P + C + 2) begin
          ent    = conf_rom[L-P-3];
          e_act  = {2'b0, ent[35:32]};
          e_mi   = ent[37:36];
          e_din  = ent[31:0];
          e_idx  = 5'd0;
          idx_on = 1;
        end else begin
          e_act = 6'd0;
        end
        if (L == P + C + 3) run_m = 1;
      end
    end
    tabs++;
  end

  // ---------------- stimulus ----------------
  task automatic at(int c);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (cyc != c && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cyc != c) begin
      errors++;
      $display("FAIL timeout waiting for cycle %0d", c);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      prog_rom[k] = 16'hA000 + 16'(k);
      conf_rom[k] = '0;
    end
    conf_rom[0] = {2'd0, 4'd3, 32'h0000_0011};
    conf_rom[1] = {2'd1, 4'd0, 32'h0000_2222};
    conf_rom[2] = {2'd3, 4'd2, 32'h1234_5678};
    conf_rom[3] = {2'd2, 4'd5, 32'hCAFE_0003};
    conf_rom[4] = {2'd1, 4'd6, 32'h0000_0044};

    reset   = 1'b1;
    restart = 1'b0;
    s_valid = 4'd0;
    tx_full = 4'd0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("lit_rst_paddr", {27'd0, prog_addr}, 0);
    chk("lit_rst_act", {26'd0, action}, 0);
    chk("lit_rst_din", din, 0);
    chk("lit_rst_run", {31'd0, running}, 0);

    at(2);
    chk("lit_i0_act", {26'd0, action}, 1);
    chk("lit_i0_din", din, 32'h0000_A000);
    at(33);
    chk("lit_i31_idx", {27'd0, index}, 31);
    chk("lit_i31_din", din, 32'h0000_A01F);
    at(37);
    chk("lit_c2_act", {26'd0, action}, 2);
    chk("lit_c2_mi", {30'd0, mindex}, 3);
    chk("lit_c2_din", din, 32'h1234_5678);
    at(39);
    chk("lit_run_lo", {31'd0, running}, 0);

    at(40);
    chk("lit_run_hi", {31'd0, running}, 1);
    s_valid = 4'hF;
    s_data  = {32'h3333_0003, 32'hDEAD_BEEF,
               32'h1111_0001, 32'h0A0A_0000};
    at(43);
    chk("lit_push_act", {26'd0, action}, 4);
    chk("lit_push_mi", {30'd0, mindex}, 2);
    chk("lit_push_din", din, 32'hDEAD_BEEF);
    at(52);
    s_valid = 4'd0;
    for (int k = 0; k < 12; k++)
      chk("lit_rr_seq", {28'd0, rlog[40+k]}, {28'd0, seq_a[k]});

    at(56);
    s_valid = 4'b0011;
    tx_full = 4'b0010;
    s_data  = {64'd0, 32'h5555_0001, 32'h5555_0000};
    at(70);
    tx_full = 4'd0;
    for (int k = 56; k < 70; k++)
      chk("lit_full_gnt", {28'd0, rlog[k]},
          (k == 56 || k == 64) ? 32'd1 : 32'd0);
    at(71);
    chk("lit_release", {28'd0, rlog[70]}, 2);
    at(74);
    s_valid = 4'd0;

    at(85);
    s_valid = 4'b0100;
    s_data  = {32'd0, 32'h0BAD_F00D, 64'd0};
    restart = 1'b1;
    at(86);
    restart = 1'b0;
    s_valid = 4'd0;
    chk("lit_rs_gnt", {28'd0, rlog[85]}, 4);
    chk("lit_rs_act", {26'd0, action}, 4);
    chk("lit_rs_din", din, 32'h0BAD_F00D);
    chk("lit_rs_run", {31'd0, running}, 0);
    chk("lit_rs_paddr", {27'd0, prog_addr}, 0);
    at(87);
    chk("lit_rs_gap", {26'd0, action}, 0);
    at(88);
    chk("lit_rs_i0", {26'd0, action}, 1);
    chk("lit_rs_i0din", din, 32'h0000_A000);

    at(122);
    chk("lit_nop_act", {26'd0, action}, 0);
    chk("lit_nop_mi", {30'd0, mindex}, 1);
    chk("lit_nop_din", din, 32'h0000_2222);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("lit_rr_paddr", {27'd0, prog_addr}, 0);
    chk("lit_rr_act", {26'd0, action}, 0);
    at(2);
    chk("lit_rr_i0", {26'd0, action}, 1);
    chk("lit_rr_idx", {27'd0, index}, 0);

    at(40);
    s_valid = 4'hF;
    s_data  = {32'h4444_0003, 32'h4444_0002,
               32'h4444_0001, 32'h4444_0000};
    at(44);
    s_valid = 4'd0;
    chk("lit_b_g0", {28'd0, rlog[40]}, 1);
    chk("lit_b_g3", {28'd0, rlog[43]}, 8);
    at(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
